// File: rtl/psc_trigger_scheduler.sv
//==============================================================================
// Module : psc_trigger_scheduler
// Brief  : Free-running frame counter plus per-channel frame-aligned trigger
//          windows with a one-deep pending queue and sticky overrun flags.
// Rev    : 1.0 - initial multi-channel release
//==============================================================================
`default_nettype none

module psc_trigger_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int FRAME_LEN   = 10,
  parameter int CNT_W       = 4,
  parameter int HOLD_FRAMES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trigger_pulse,
  input  logic              miss_clear,
  output logic [CNT_W-1:0]  tx_counter,
  output logic              frame_start,
  output logic [NUM_CH-1:0] is_trigger,
  output logic [NUM_CH-1:0] trig_busy,
  output logic [NUM_CH-1:0] missed_pulse
);

  localparam int              HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(FRAME_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  logic [CNT_W-1:0] cnt;
  logic             tx_done;

  assign tx_done     = (cnt == LAST_SLOT);
  assign tx_counter  = cnt;
  assign frame_start = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tx_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic              pend, pend_nx;
    logic              miss, miss_set;
    logic              pulse;

    assign pulse = trigger_pulse[ch];

    always_comb begin
      state_nx = state;
      hold_nx  = hold;
      pend_nx  = pend;
      miss_set = 1'b0;
      case (state)
        ST_IDLE: begin
          if (pulse) state_nx = ST_WAIT;
        end
        ST_WAIT: begin
          if (pulse) begin
            if (pend) miss_set = 1'b1;
            else      pend_nx  = 1'b1;
          end
          if (tx_done) begin
            state_nx = ST_LOAD;
            hold_nx  = '0;
          end
        end
        ST_LOAD: begin
          if (tx_done && (hold == HOLD_LAST)) begin
            // A pulse arriving as the queued one is consumed re-arms the queue
            if (pend) begin
              state_nx = ST_WAIT;
              pend_nx  = pulse;
            end else if (pulse) begin
              state_nx = ST_WAIT;
            end else begin
              state_nx = ST_IDLE;
            end
          end else begin
            if (tx_done) hold_nx = hold + 1'b1;
            if (pulse) begin
              if (pend) miss_set = 1'b1;
              else      pend_nx  = 1'b1;
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
          hold_nx  = '0;
          pend_nx  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= ST_IDLE;
        hold  <= '0;
        pend  <= 1'b0;
        miss  <= 1'b0;
      end else begin
        state <= state_nx;
        hold  <= hold_nx;
        pend  <= pend_nx;
        miss  <= miss_set | (miss & ~miss_clear);
      end
    end

    assign is_trigger[ch]   = (state == ST_LOAD);
    assign trig_busy[ch]    = (state != ST_IDLE);
    assign missed_pulse[ch] = miss;
  end

endmodule

`default_nettype wire
